// File: rtl/credit_sender_pkg.sv
// Shared credit-link definitions used by both the sender and receiver sides.
package credit_sender_pkg;

  localparam int DEFAULT_BIT_WIDTH   = 32;
  localparam int DEFAULT_NUM_CREDITS = 4;

  // Width needed to hold every count from 0 up to and including n.
  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter; a simultaneous inc and dec leaves the count unchanged.
module credit_counter
  import credit_sender_pkg::*;
#(
  parameter int CW          = 3,
  parameter int NUM_CREDITS = DEFAULT_NUM_CREDITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero,
  output logic          full,
  output logic          ovf
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_CREDITS);

  assign zero = (count == '0);
  assign full = (count == MAX_COUNT);
  assign ovf  = inc & ~dec & full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= MAX_COUNT;
    end else if (inc && !dec && !full) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/credit_sender.sv
// Val/rdy to credit-link bridge: registered output stage gated by the downstream credit count.
module credit_sender
  import credit_sender_pkg::*;
#(
  parameter  int BIT_WIDTH   = DEFAULT_BIT_WIDTH,
  parameter  int NUM_CREDITS = DEFAULT_NUM_CREDITS,
  localparam int CW          = credit_width(NUM_CREDITS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] in_msg,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [BIT_WIDTH-1:0] out_msg,
  output logic                 out_val,
  input  logic                 credit_return,
  output logic [CW-1:0]        credits,
  output logic                 idle,
  output logic                 overflow_err
);

  logic xfer;
  logic cnt_zero;
  logic cnt_full;
  logic cnt_ovf;

  credit_counter #(
    .CW          (CW),
    .NUM_CREDITS (NUM_CREDITS)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (credit_return),
    .dec   (xfer),
    .count (credits),
    .zero  (cnt_zero),
    .full  (cnt_full),
    .ovf   (cnt_ovf)
  );

  // in_rdy comes from the counter register only, so no comb path from in_val or credit_return.
  assign in_rdy = ~cnt_zero;
  assign xfer   = in_val & in_rdy;
  assign idle   = cnt_full & ~out_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val      <= 1'b0;
      out_msg      <= '0;
      overflow_err <= 1'b0;
    end else begin
      out_val <= xfer;
      if (xfer) begin
        out_msg <= in_msg;
      end
      if (cnt_ovf) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender: directed scenarios plus randomized traffic against a count-based model.
module tb_credit_sender;

  localparam int BW = 32;
  localparam int NC = 4;
  localparam int CW = $clog2(NC + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] in_msg;
  logic          in_val;
  logic          in_rdy;
  logic [BW-1:0] out_msg;
  logic          out_val;
  logic          credit_return;
  logic [CW-1:0] credits;
  logic          idle;
  logic          overflow_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a plain credit tally and the last message delivered.
  int            m_cred;
  logic          m_oval;
  logic [BW-1:0] m_omsg;
  logic          m_err;

  credit_sender #(.BIT_WIDTH(BW), .NUM_CREDITS(NC)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_msg        (in_msg),
    .in_val        (in_val),
    .in_rdy        (in_rdy),
    .out_msg       (out_msg),
    .out_val       (out_val),
    .credit_return (credit_return),
    .credits       (credits),
    .idle          (idle),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cred = NC;
    m_oval = 1'b0;
    m_omsg = '0;
    m_err  = 1'b0;
  endtask

  // Advance one clock with the currently driven inputs; returns at the following negedge.
  task automatic tick();
    bit acc;
    acc = in_val && (m_cred > 0);
    @(posedge clk);
    m_oval = acc;
    if (acc) m_omsg = in_msg;
    if (credit_return && !acc && m_cred == NC) m_err = 1'b1;
    m_cred = m_cred - (acc ? 1 : 0) + (credit_return ? 1 : 0);
    if (m_cred > NC) m_cred = NC;
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_val = 1'b0; credit_return = 1'b0; in_msg = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (credits !== CW'(4)) begin miscompares++; $display("FAIL reset_credits got %0d want 4", credits); end
    vectors++;
    if (in_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    vectors++;
    if (out_val !== 1'b0) begin miscompares++; $display("FAIL reset_out_val got %b want 0", out_val); end
    vectors++;
    if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle got %b want 1", idle); end
    vectors++;
    if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
  endtask

  task automatic test_burst();
    logic [BW-1:0] exp_msg;
    for (int i = 0; i < 6; i++) begin
      in_val = 1'b1;
      in_msg = BW'(32'hA0 + i);
      vectors++;
      if (in_rdy !== (i < 4)) begin miscompares++; $display("FAIL burst_in_rdy[%0d] got %b want %b", i, in_rdy, (i < 4)); end
      vectors++;
      if (credits !== CW'(i < 4 ? 4 - i : 0)) begin
        miscompares++; $display("FAIL burst_credits[%0d] got %0d want %0d", i, credits, (i < 4 ? 4 - i : 0));
      end
      tick();
      exp_msg = BW'(32'hA0 + (i < 4 ? i : 3));
      vectors++;
      if (out_val !== (i < 4)) begin miscompares++; $display("FAIL burst_out_val[%0d] got %b want %b", i, out_val, (i < 4)); end
      vectors++;
      if (out_msg !== exp_msg) begin miscompares++; $display("FAIL burst_out_msg[%0d] got %h want %h", i, out_msg, exp_msg); end
    end
    vectors++;
    if (credits !== CW'(0)) begin miscompares++; $display("FAIL burst_final_credits got %0d want 0", credits); end
  endtask

  task automatic test_bubble();
    in_val = 1'b1; in_msg = 32'hA4; credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    vectors++;
    if (credits !== CW'(1)) begin miscompares++; $display("FAIL bubble_credits got %0d want 1", credits); end
    vectors++;
    if (in_rdy !== 1'b1) begin miscompares++; $display("FAIL bubble_in_rdy got %b want 1", in_rdy); end
    vectors++;
    if (out_val !== 1'b0) begin miscompares++; $display("FAIL bubble_out_val got %b want 0", out_val); end
    tick();
    in_val = 1'b0;
    vectors++;
    if (out_val !== 1'b1 || out_msg !== 32'hA4) begin
      miscompares++; $display("FAIL bubble_deliver got val=%b msg=%h want val=1 msg=a4", out_val, out_msg);
    end
    vectors++;
    if (credits !== CW'(0)) begin miscompares++; $display("FAIL bubble_credits_after got %0d want 0", credits); end
  endtask

  task automatic test_simultaneous();
    logic [BW-1:0] msg;
    in_val = 1'b0; credit_return = 1'b1;
    repeat (2) tick();
    vectors++;
    if (credits !== CW'(2)) begin miscompares++; $display("FAIL simul_setup got %0d want 2", credits); end
    for (int i = 0; i < 3; i++) begin
      msg = $urandom;
      in_val = 1'b1; in_msg = msg; credit_return = 1'b1;
      tick();
      vectors++;
      if (credits !== CW'(2)) begin miscompares++; $display("FAIL simul_credits[%0d] got %0d want 2", i, credits); end
      vectors++;
      if (out_val !== 1'b1 || out_msg !== msg) begin
        miscompares++; $display("FAIL simul_out[%0d] got val=%b msg=%h want val=1 msg=%h", i, out_val, out_msg, msg);
      end
    end
    in_val = 1'b0; credit_return = 1'b0;
  endtask

  task automatic test_overflow();
    credit_return = 1'b1;
    repeat (2) tick();
    credit_return = 1'b0;
    tick();
    vectors++;
    if (credits !== CW'(4) || idle !== 1'b1 || overflow_err !== 1'b0) begin
      miscompares++; $display("FAIL ovf_setup got credits=%0d idle=%b err=%b want 4 1 0", credits, idle, overflow_err);
    end
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    vectors++;
    if (credits !== CW'(4)) begin miscompares++; $display("FAIL ovf_saturate got %0d want 4", credits); end
    vectors++;
    if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", overflow_err); end
    repeat (3) tick();
    vectors++;
    if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
  endtask

  task automatic test_reset_mid_burst();
    in_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_msg = $urandom | 32'h1;
      tick();
    end
    vectors++;
    if (credits !== CW'(1) || out_val !== 1'b1) begin
      miscompares++; $display("FAIL midrst_setup got credits=%0d val=%b want 1 1", credits, out_val);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (credits !== CW'(4)) begin miscompares++; $display("FAIL midrst_credits got %0d want 4", credits); end
    vectors++;
    if (out_val !== 1'b0 || out_msg !== '0) begin
      miscompares++; $display("FAIL midrst_out got val=%b msg=%h want 0 0", out_val, out_msg);
    end
    vectors++;
    if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL midrst_ovf got %b want 0", overflow_err); end
    in_val = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_val        = ($urandom_range(0, 3) != 0);
      credit_return = ($urandom_range(0, 2) == 0);
      in_msg        = $urandom;
      vectors++;
      if (in_rdy !== (m_cred > 0)) begin miscompares++; $display("FAIL rand_in_rdy[%0d] got %b want %b", i, in_rdy, (m_cred > 0)); end
      tick();
      vectors++;
      if (credits !== CW'(m_cred)) begin miscompares++; $display("FAIL rand_credits[%0d] got %0d want %0d", i, credits, m_cred); end
      vectors++;
      if (out_val !== m_oval || out_msg !== m_omsg) begin
        miscompares++; $display("FAIL rand_out[%0d] got val=%b msg=%h want val=%b msg=%h", i, out_val, out_msg, m_oval, m_omsg);
      end
      vectors++;
      if (idle !== (m_cred == NC && !m_oval)) begin miscompares++; $display("FAIL rand_idle[%0d] got %b", i, idle); end
      vectors++;
      if (overflow_err !== m_err) begin miscompares++; $display("FAIL rand_ovf[%0d] got %b want %b", i, overflow_err, m_err); end
    end
    in_val = 1'b0; credit_return = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; credit_return = 1'b0; in_msg = '0;
    @(negedge clk);
    test_reset();
    test_burst();
    test_bubble();
    test_simultaneous();
    test_overflow();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
